// File: rtl/bcd_pkg.sv
// Shared types and helpers for the two-digit BCD adder front end.
// Digit type, loader state encoding and the BCD range check.
package bcd_pkg;

    localparam int BCD_MAX = 9;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        READY  = 2'b10
    } loader_state_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return d <= bcd_digit_t'(BCD_MAX);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces the active-low load key.
// Emits a one-cycle press pulse on a debounced fall.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [1:0]    flushed;
    logic          armed;
    logic          level;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          flip;

    assign differ = (sync2 != level);
    assign flip   = differ && (cnt == CNT_LAST);

    // Two-flop synchroniser, idles at the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Marks when sync2 carries a real pin sample, not its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flushed <= 2'b00;
        end else begin
            flushed <= {flushed[0], 1'b1};
        end
    end

    // Presses are enabled only after the key is seen released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (flushed[1] && sync2) begin
            armed <= 1'b1;
        end
    end

    // Stability counter; the level follows only a long-lasting change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b1;
        end else if (!differ) begin
            cnt <= '0;
        end else if (flip) begin
            cnt   <= '0;
            level <= ~level;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pulse in the cycle right after the level drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press <= 1'b0;
        end else begin
            press <= flip && level && armed;
        end
    end

endmodule

// File: rtl/bcd_operand_loader.sv
// Loads operand A then B from the switches on key presses.
// Holds the pair and flags it valid for the adder and display.
module bcd_operand_loader
    import bcd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [7:0] SW_data,
    input  logic       load_n,
    output logic [3:0] A1,
    output logic [3:0] A0,
    output logic [3:0] B1,
    output logic [3:0] B0,
    output logic       operands_valid,
    output logic       bcd_err,
    output logic [1:0] state_led
);

    logic [7:0]    sw_s1;
    logic [7:0]    sw_s2;
    logic          press;
    logic          sw_ok;
    bcd_digit_t    tens;
    bcd_digit_t    units;
    loader_state_t state;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk  (CLOCK_50),
        .rst_n(Resetn),
        .key_n(load_n),
        .press(press)
    );

    // Switches are asynchronous; sample them through two flops.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= SW_data;
            sw_s2 <= sw_s1;
        end
    end

    assign tens      = sw_s2[7:4];
    assign units     = sw_s2[3:0];
    assign sw_ok     = is_bcd(tens) && is_bcd(units);
    assign state_led = state;

    // Loader FSM with its operand, valid and error registers.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state          <= WAIT_A;
            A1             <= '0;
            A0             <= '0;
            B1             <= '0;
            B0             <= '0;
            operands_valid <= 1'b0;
            bcd_err        <= 1'b0;
        end else begin
            case (state)
                WAIT_A: begin
                    if (press) begin
                        if (sw_ok) begin
                            A1      <= tens;
                            A0      <= units;
                            B1      <= '0;
                            B0      <= '0;
                            bcd_err <= 1'b0;
                            state   <= WAIT_B;
                        end else begin
                            bcd_err <= 1'b1;
                        end
                    end
                end
                WAIT_B: begin
                    if (press) begin
                        if (sw_ok) begin
                            B1             <= tens;
                            B0             <= units;
                            bcd_err        <= 1'b0;
                            operands_valid <= 1'b1;
                            state          <= READY;
                        end else begin
                            bcd_err <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (press) begin
                        if (sw_ok) begin
                            A1             <= tens;
                            A0             <= units;
                            B1             <= '0;
                            B0             <= '0;
                            operands_valid <= 1'b0;
                            bcd_err        <= 1'b0;
                            state          <= WAIT_B;
                        end else begin
                            bcd_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= WAIT_A;
                end
            endcase
        end
    end

endmodule
